// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two ALU requesters, the response consumer
// and the shared-ALU arbiter.
interface alu_share_arb_if #(
  parameter int REG_WIDTH = 32
);
  logic                 req_valid_0;
  logic                 req_valid_1;
  logic [REG_WIDTH-1:0] req_in1_0;
  logic [REG_WIDTH-1:0] req_in1_1;
  logic [REG_WIDTH-1:0] req_in2_0;
  logic [REG_WIDTH-1:0] req_in2_1;
  logic [3:0]           req_ctrl_0;
  logic [3:0]           req_ctrl_1;
  logic                 req_ready_0;
  logic                 req_ready_1;
  logic                 rsp_valid;
  logic [REG_WIDTH-1:0] rsp_data;
  logic                 rsp_id;
  logic                 rsp_ready;

  modport master (
    output req_valid_0, req_valid_1, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
           req_ctrl_0, req_ctrl_1, rsp_ready,
    input  req_ready_0, req_ready_1, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
           req_ctrl_0, req_ctrl_1, rsp_ready,
    output req_ready_0, req_ready_1, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one execute-stage ALU between two requesters, with a
// one-entry backpressured result register tagged by the winning requester.
module alu_share_arb #(
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  alu_share_arb_if.slave       bus,
  output logic [REG_WIDTH-1:0] alu_in1,
  output logic [REG_WIDTH-1:0] alu_in2,
  output logic [3:0]           alu_control,
  input  logic [REG_WIDTH-1:0] alu_result,
  output logic [CNT_WIDTH-1:0] grant_cnt_0,
  output logic [CNT_WIDTH-1:0] grant_cnt_1
);
  localparam logic [3:0]           CTRL_ADD = 4'b0010;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 rsp_valid_r;
  logic [REG_WIDTH-1:0] rsp_data_r;
  logic                 rsp_id_r;
  logic                 prio_r;
  logic [CNT_WIDTH-1:0] cnt_0_r;
  logic [CNT_WIDTH-1:0] cnt_1_r;
  logic                 can_issue_s;
  logic                 grant_0_s;
  logic                 grant_1_s;
  logic                 any_grant_s;

  assign can_issue_s = !rsp_valid_r || bus.rsp_ready;
  assign any_grant_s = grant_0_s || grant_1_s;

  // Grant selection; no grants while reset is asserted or the output register is stuck.
  always_comb begin
    grant_0_s = 1'b0;
    grant_1_s = 1'b0;
    if (reset_b && can_issue_s) begin
      if (bus.req_valid_0 && bus.req_valid_1) begin
        grant_0_s = !prio_r;
        grant_1_s = prio_r;
      end else begin
        grant_0_s = bus.req_valid_0;
        grant_1_s = bus.req_valid_1;
      end
    end else begin
      grant_0_s = 1'b0;
      grant_1_s = 1'b0;
    end
  end

  // Operand/control mux to the shared ALU; idle value is a deterministic 0 + 0.
  always_comb begin
    alu_in1     = {REG_WIDTH{1'b0}};
    alu_in2     = {REG_WIDTH{1'b0}};
    alu_control = CTRL_ADD;
    case ({grant_1_s, grant_0_s})
      2'b01: begin
        alu_in1     = bus.req_in1_0;
        alu_in2     = bus.req_in2_0;
        alu_control = bus.req_ctrl_0;
      end
      2'b10: begin
        alu_in1     = bus.req_in1_1;
        alu_in2     = bus.req_in2_1;
        alu_control = bus.req_ctrl_1;
      end
      default: begin
        alu_in1     = {REG_WIDTH{1'b0}};
        alu_in2     = {REG_WIDTH{1'b0}};
        alu_control = CTRL_ADD;
      end
    endcase
  end

  // Output register and round-robin pointer; a grant always refills, even while draining.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {REG_WIDTH{1'b0}};
      rsp_id_r    <= 1'b0;
      prio_r      <= 1'b0;
    end else if (any_grant_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= alu_result;
      rsp_id_r    <= grant_1_s;
      prio_r      <= !grant_1_s;
    end else if (rsp_valid_r && bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_0_r <= {CNT_WIDTH{1'b0}};
      cnt_1_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (grant_0_s && (cnt_0_r != CNT_MAX)) cnt_0_r <= cnt_0_r + CNT_ONE;
      if (grant_1_s && (cnt_1_r != CNT_MAX)) cnt_1_r <= cnt_1_r + CNT_ONE;
    end
  end

  assign bus.req_ready_0 = grant_0_s;
  assign bus.req_ready_1 = grant_1_s;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.rsp_id      = rsp_id_r;
  assign grant_cnt_0     = cnt_0_r;
  assign grant_cnt_1     = cnt_1_r;
endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized traffic
// against a transaction-level reference model; a second instance checks saturation.
module tb_alu_share_arb;
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  alu_share_arb_if #(.REG_WIDTH(32)) bus ();
  alu_share_arb_if #(.REG_WIDTH(32)) bus_s ();

  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [3:0]  alu_control;
  logic [15:0] grant_cnt_0, grant_cnt_1;
  logic [31:0] s_in1, s_in2, s_result;
  logic [3:0]  s_control;
  logic [1:0]  s_cnt_0, s_cnt_1;

  // Reference ALU: MIPS-style encoding, unlisted codes add.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a + b;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_in1, alu_in2, alu_control);
  assign s_result   = alu_ref(s_in1, s_in2, s_control);

  alu_share_arb #(.REG_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_b(reset_b), .bus(bus),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
  );

  // Saturation instance sees exactly the same traffic with 2-bit counters.
  assign bus_s.req_valid_0 = bus.req_valid_0;
  assign bus_s.req_valid_1 = bus.req_valid_1;
  assign bus_s.req_in1_0   = bus.req_in1_0;
  assign bus_s.req_in1_1   = bus.req_in1_1;
  assign bus_s.req_in2_0   = bus.req_in2_0;
  assign bus_s.req_in2_1   = bus.req_in2_1;
  assign bus_s.req_ctrl_0  = bus.req_ctrl_0;
  assign bus_s.req_ctrl_1  = bus.req_ctrl_1;
  assign bus_s.rsp_ready   = bus.rsp_ready;

  alu_share_arb #(.REG_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_b(reset_b), .bus(bus_s),
    .alu_in1(s_in1), .alu_in2(s_in2), .alu_control(s_control),
    .alu_result(s_result), .grant_cnt_0(s_cnt_0), .grant_cnt_1(s_cnt_1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model state.
  logic        m_valid, m_id, m_prio;
  logic [31:0] m_data;
  logic [15:0] m_cnt0, m_cnt1;
  logic        e_g0, e_g1;

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_prio = 1'b0; m_data = 32'd0;
    m_cnt0 = 16'd0; m_cnt1 = 16'd0;
  endtask

  // Who should win this cycle, from the arbitration rules.
  task automatic model_comb();
    e_g0 = 1'b0; e_g1 = 1'b0;
    if (reset_b && (!m_valid || bus.rsp_ready)) begin
      if (bus.req_valid_0 && bus.req_valid_1) begin
        if (m_prio) e_g1 = 1'b1; else e_g0 = 1'b1;
      end else begin
        e_g0 = bus.req_valid_0;
        e_g1 = bus.req_valid_1;
      end
    end
  endtask

  task automatic model_commit();
    if (e_g0) begin
      m_data = alu_ref(bus.req_in1_0, bus.req_in2_0, bus.req_ctrl_0);
      m_id = 1'b0; m_valid = 1'b1; m_prio = 1'b1;
      if (m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
    end else if (e_g1) begin
      m_data = alu_ref(bus.req_in1_1, bus.req_in2_1, bus.req_ctrl_1);
      m_id = 1'b1; m_valid = 1'b1; m_prio = 1'b0;
      if (m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [1:0] sat2(input logic [15:0] v);
    return (v > 16'd3) ? 2'd3 : v[1:0];
  endfunction

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic commit();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    bus.req_valid_0 = 1'b1; bus.req_in1_0 = $urandom; bus.req_in2_0 = $urandom; bus.req_ctrl_0 = 4'b0010;
    bus.req_valid_1 = 1'b1; bus.req_in1_1 = $urandom; bus.req_in2_1 = $urandom; bus.req_ctrl_1 = 4'b0001;
    bus.rsp_ready = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
    n_cmp++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); end
    n_cmp++; if ({bus.req_ready_1, bus.req_ready_0} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", {bus.req_ready_1, bus.req_ready_0}); end
    n_cmp++; if ({alu_in1, alu_in2, alu_control} !== {32'd0, 32'd0, 4'b0010}) begin n_err++; $display("FAIL reset_alu got %h %h %b want 0 0 0010", alu_in1, alu_in2, alu_control); end
    n_cmp++; if ({grant_cnt_0, grant_cnt_1} !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d %0d want 0 0", grant_cnt_0, grant_cnt_1); end
    reset_b = 1'b1;
    settle();
    n_cmp++; if ({bus.req_ready_1, bus.req_ready_0} !== 2'b01) begin n_err++; $display("FAIL post_reset_grant got %b want 01", {bus.req_ready_1, bus.req_ready_0}); end
    commit();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, m_data}) begin n_err++; $display("FAIL post_reset_rsp got %b %b %h want 1 0 %h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_data); end
  endtask

  task automatic test_single();
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0; bus.rsp_ready = 1'b1;
    settle(); commit();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", bus.rsp_valid); end
    bus.req_valid_0 = 1'b1; bus.req_in1_0 = 32'd5; bus.req_in2_0 = 32'd3; bus.req_ctrl_0 = 4'b0110;
    settle();
    n_cmp++; if ({bus.req_ready_0, alu_in1, alu_in2, alu_control} !== {1'b1, 32'd5, 32'd3, 4'b0110}) begin n_err++; $display("FAIL single_mux got %b %h %h %b want 1 5 3 0110", bus.req_ready_0, alu_in1, alu_in2, alu_control); end
    commit();
    bus.req_valid_0 = 1'b0;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 32'd2}) begin n_err++; $display("FAIL single_rsp got %b %b %h want 1 0 2", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
    n_cmp++; if (grant_cnt_0 !== m_cnt0) begin n_err++; $display("FAIL single_cnt0 got %0d want %0d", grant_cnt_0, m_cnt0); end
  endtask

  task automatic test_contention();
    logic last_win;
    bus.req_valid_0 = 1'b1; bus.req_in1_0 = 32'd1; bus.req_in2_0 = 32'd1; bus.req_ctrl_0 = 4'b0010;
    bus.req_valid_1 = 1'b1; bus.req_in1_1 = 32'hF0; bus.req_in2_1 = 32'h3C; bus.req_ctrl_1 = 4'b0000;
    bus.rsp_ready = 1'b1;
    last_win = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if ({bus.req_ready_1, bus.req_ready_0} !== {e_g1, e_g0}) begin n_err++; $display("FAIL contend_grant[%0d] got %b want %b", i, {bus.req_ready_1, bus.req_ready_0}, {e_g1, e_g0}); end
      if (i > 0) begin
        n_cmp++; if (bus.req_ready_1 !== !last_win) begin n_err++; $display("FAIL contend_alternate[%0d] got %b want %b", i, bus.req_ready_1, !last_win); end
      end
      last_win = bus.req_ready_1;
      commit();
      n_cmp++; if ({bus.rsp_id, bus.rsp_data} !== {m_id, (m_id ? 32'h30 : 32'd2)}) begin n_err++; $display("FAIL contend_rsp[%0d] got %b %h want %b %h", i, bus.rsp_id, bus.rsp_data, m_id, (m_id ? 32'h30 : 32'd2)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bus.req_valid_1 = 1'b0;
    bus.req_in1_0 = $urandom; bus.req_in2_0 = $urandom; bus.req_ctrl_0 = 4'b0001;
    settle(); commit();
    held = m_data;
    bus.rsp_ready = 1'b0; bus.req_valid_1 = 1'b1; bus.req_in1_1 = 32'd100; bus.req_in2_1 = 32'd58; bus.req_ctrl_1 = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if ({bus.req_ready_1, bus.req_ready_0} !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 00", i, {bus.req_ready_1, bus.req_ready_0}); end
      commit();
      n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, held}) begin n_err++; $display("FAIL bp_hold[%0d] got %b %b %h want 1 0 %h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, held); end
    end
    bus.rsp_ready = 1'b1;
    settle();
    n_cmp++; if ({bus.req_ready_1, bus.req_ready_0} !== {e_g1, e_g0} || !(e_g0 || e_g1)) begin n_err++; $display("FAIL bp_refill_grant got %b want %b", {bus.req_ready_1, bus.req_ready_0}, {e_g1, e_g0}); end
    commit();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, m_id, m_data}) begin n_err++; $display("FAIL bp_refill_rsp got %b %b %h want 1 %b %h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_id, m_data); end
  endtask

  task automatic test_mid_reset();
    bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b0; bus.rsp_ready = 1'b1;
    bus.req_in1_0 = $urandom; bus.req_in2_0 = $urandom;
    settle(); commit();
    bus.req_valid_0 = 1'b0; bus.rsp_ready = 1'b0; bus.req_valid_1 = 1'b1;
    bus.req_in1_1 = $urandom; bus.req_in2_1 = $urandom; bus.req_ctrl_1 = 4'b1100;
    #2;
    reset_b = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b0, 32'd0}) begin n_err++; $display("FAIL midreset_rsp got %b %h want 0 0", bus.rsp_valid, bus.rsp_data); end
    n_cmp++; if ({grant_cnt_0, grant_cnt_1, bus.req_ready_1} !== 33'd0) begin n_err++; $display("FAIL midreset_cnt got %0d %0d rdy %b want 0 0 0", grant_cnt_0, grant_cnt_1, bus.req_ready_1); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL midreset_hold got %b want 0", bus.rsp_valid); end
    reset_b = 1'b1;
    settle(); commit();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, m_data}) begin n_err++; $display("FAIL midreset_after got %b %b %h want 1 1 %h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_data); end
  endtask

  task automatic test_saturation();
    bus.req_valid_0 = 1'b0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid_1 = 1'b1; bus.req_in1_1 = $urandom; bus.req_in2_1 = $urandom;
      settle(); commit();
    end
    bus.req_valid_1 = 1'b0;
    n_cmp++; if (s_cnt_1 !== 2'd3) begin n_err++; $display("FAIL sat_cnt1 got %0d want 3", s_cnt_1); end
    n_cmp++; if (grant_cnt_1 !== 16'd5) begin n_err++; $display("FAIL wide_cnt1 got %0d want 5", grant_cnt_1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!bus.req_valid_0 || e_g0) begin
        bus.req_valid_0 = $urandom_range(0, 1) == 1;
        bus.req_in1_0 = $urandom; bus.req_in2_0 = $urandom; bus.req_ctrl_0 = 4'($urandom);
      end
      if (!bus.req_valid_1 || e_g1) begin
        bus.req_valid_1 = $urandom_range(0, 2) != 0;
        bus.req_in1_1 = $urandom; bus.req_in2_1 = $urandom; bus.req_ctrl_1 = 4'($urandom);
      end
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      settle();
      n_cmp++; if ({bus.req_ready_1, bus.req_ready_0} !== {e_g1, e_g0}) begin n_err++; $display("FAIL rand_grant[%0d] got %b want %b", i, {bus.req_ready_1, bus.req_ready_0}, {e_g1, e_g0}); end
      commit();
      n_cmp++; if (bus.rsp_valid !== m_valid) begin n_err++; $display("FAIL rand_valid[%0d] got %b want %b", i, bus.rsp_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if ({bus.rsp_id, bus.rsp_data} !== {m_id, m_data}) begin n_err++; $display("FAIL rand_rsp[%0d] got %b %h want %b %h", i, bus.rsp_id, bus.rsp_data, m_id, m_data); end
      end
      n_cmp++; if ({grant_cnt_0, grant_cnt_1, s_cnt_0, s_cnt_1} !== {m_cnt0, m_cnt1, sat2(m_cnt0), sat2(m_cnt1)}) begin n_err++; $display("FAIL rand_cnt[%0d] got %0d %0d %0d %0d want %0d %0d %0d %0d", i, grant_cnt_0, grant_cnt_1, s_cnt_0, s_cnt_1, m_cnt0, m_cnt1, sat2(m_cnt0), sat2(m_cnt1)); end
    end
  endtask

  initial begin
    e_g0 = 1'b0; e_g1 = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
